// File: rtl/instr_prefetch_if.sv
// instr_prefetch_if: datapath fetch port and instruction memory request/response bus
interface instr_prefetch_if;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        input  pc, mem_gnt, mem_rvalid, mem_rdata,
        output instr, instr_valid, mem_req, mem_addr
    );

    modport slave (
        output pc, mem_gnt, mem_rvalid, mem_rdata,
        input  instr, instr_valid, mem_req, mem_addr
    );
endinterface

// File: rtl/instr_prefetch.sv
// instr_prefetch: sequential instruction prefetch queue in front of a variable-latency memory
module instr_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic             clk,
    input  logic             reset,
    instr_prefetch_if.master bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [31:0]   r_q [DEPTH];
    logic [AW-1:0] r_rd, r_wr;
    logic [CW-1:0] r_count, r_live, r_stale;
    logic [31:0]   r_hpc, r_fpc, r_addr;
    logic          r_req, r_req_stale;

    logic          w_redirect, w_valid, w_grant, w_stale_grant, w_live_grant;
    logic          w_rsp_stale, w_rsp_live, w_push, w_issue;
    logic [CW-1:0] w_count_n, w_live_n, w_stale_n;
    logic [CW+1:0] w_occ;
    logic [31:0]   w_base;

    assign bus.instr_valid = w_valid;
    assign bus.instr       = r_count != '0 ? r_q[r_rd] : '0;
    assign bus.mem_req     = r_req;
    assign bus.mem_addr    = r_addr;

    // Next-state bookkeeping; issue decisions use post-edge occupancy so a redirect frees the queue at once
    always_comb begin
        w_redirect    = bus.pc != r_hpc;
        w_valid       = !w_redirect && r_count != '0;
        w_grant       = r_req && bus.mem_gnt;
        w_stale_grant = w_grant && (r_req_stale || w_redirect);
        w_live_grant  = w_grant && !w_stale_grant;
        w_rsp_stale   = bus.mem_rvalid && r_stale != '0;
        w_rsp_live    = bus.mem_rvalid && r_stale == '0;
        w_push        = w_rsp_live && !w_redirect;
        w_count_n     = w_redirect ? '0 : r_count + CW'(w_push) - CW'(w_valid);
        w_live_n      = w_redirect ? '0 : r_live + CW'(w_live_grant) - CW'(w_rsp_live);
        w_stale_n     = r_stale + CW'(w_stale_grant) - CW'(w_rsp_stale)
                      + (w_redirect ? r_live - CW'(w_rsp_live) : '0);
        w_occ         = (CW+2)'(w_count_n) + (CW+2)'(w_live_n) + (CW+2)'(w_stale_n);
        w_issue       = (!r_req || w_grant) && w_occ < (CW+2)'(DEPTH);
        w_base        = w_redirect ? bus.pc : r_fpc;
    end

    // Control state: stream addresses, counters, queue pointers and the held memory request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hpc       <= RESET_PC;
            r_fpc       <= RESET_PC;
            r_addr      <= RESET_PC;
            r_req       <= 1'b0;
            r_req_stale <= 1'b0;
            r_count     <= '0;
            r_live      <= '0;
            r_stale     <= '0;
            r_rd        <= '0;
            r_wr        <= '0;
        end else begin
            r_count     <= w_count_n;
            r_live      <= w_live_n;
            r_stale     <= w_stale_n;
            r_hpc       <= w_redirect ? bus.pc : r_hpc + (w_valid ? 32'd4 : 32'd0);
            r_rd        <= w_redirect ? '0 : r_rd + AW'(w_valid);
            r_wr        <= w_redirect ? '0 : r_wr + AW'(w_push);
            r_req_stale <= !w_grant && (r_req_stale || (w_redirect && r_req));
            r_req       <= w_issue || (r_req && !w_grant);
            r_addr      <= w_issue ? w_base : r_addr;
            r_fpc       <= w_base + (w_issue ? 32'd4 : 32'd0);
        end
    end

    // Queue data storage; validity is tracked by the counters, so no reset is needed
    always_ff @(posedge clk) begin
        if (w_push) r_q[r_wr] <= bus.mem_rdata;
    end
endmodule

// File: tb/tb_instr_prefetch.sv
// tb_instr_prefetch: randomized memory/datapath environment with a behavioural fetch model
module tb_instr_prefetch;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    instr_prefetch_if bus();

    instr_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = -1;
    int gnt_pct = 100;
    int rsp_pct = 100;
    int jump_pct = 0;
    int n_grants = 0;
    int n_valid = 0;
    int idle = 0;
    logic live_chk = 1'b0;
    logic rst_hold = 1'b1;
    logic force_jump = 1'b0;
    logic [31:0] force_pc = 32'h0;
    logic [31:0] next_pc = 32'h0;
    logic prev_req = 1'b0;
    logic prev_gnt = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic [31:0] pend_addr[$];
    int pend_rdy[$];
    logic log_req[200];
    logic log_valid[200];
    logic [31:0] log_addr[200];
    logic [31:0] log_instr[200];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5A5A5;
    endfunction

    function automatic logic [31:0] rand_pc();
        if ($urandom_range(1) == 1) return $urandom() & 32'hFFFF_FFFC;
        return 32'hFFFF_FFF0 + 32'($urandom_range(3) * 4);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        reset = rst_hold;
        if (rst_hold) begin
            pend_addr.delete();
            pend_rdy.delete();
            bus.pc = 32'h0;
            next_pc = 32'h0;
            bus.mem_gnt = 1'b0;
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata = 32'h0;
            prev_req = 1'b0;
            prev_gnt = 1'b0;
            cyc = -1;
            #1;
            return;
        end
        cyc++;
        if (force_jump) bus.pc = force_pc;
        else if (int'($urandom_range(99)) < jump_pct) bus.pc = rand_pc();
        else bus.pc = next_pc;
        force_jump = 1'b0;
        bus.mem_rvalid = pend_addr.size() > 0 && pend_rdy[0] <= cyc && int'($urandom_range(99)) < rsp_pct;
        bus.mem_rdata = bus.mem_rvalid ? mem_word(pend_addr[0]) : $urandom();
        if (bus.mem_rvalid) begin
            void'(pend_addr.pop_front());
            void'(pend_rdy.pop_front());
        end
        bus.mem_gnt = bus.mem_req && int'($urandom_range(99)) < gnt_pct;
        if (bus.mem_gnt) begin
            pend_addr.push_back(bus.mem_addr);
            pend_rdy.push_back(cyc + 1);
            n_grants++;
            check("outstanding_bound", 32'(pend_addr.size() <= DEPTH), 32'd1);
        end
        #1;
        if (prev_req && !prev_gnt) begin
            check("req_held", 32'(bus.mem_req), 32'd1);
            check("addr_held", bus.mem_addr, prev_addr);
        end
        if (bus.instr_valid) begin
            check("instr_data", bus.instr, mem_word(bus.pc));
            n_valid++;
            idle = 0;
        end else begin
            idle++;
        end
        if (live_chk) check("progress", 32'(idle <= 150), 32'd1);
        if (cyc < 200) begin
            log_req[cyc] = bus.mem_req;
            log_addr[cyc] = bus.mem_addr;
            log_valid[cyc] = bus.instr_valid;
            log_instr[cyc] = bus.instr;
        end
        prev_req = bus.mem_req;
        prev_gnt = bus.mem_gnt;
        prev_addr = bus.mem_addr;
        next_pc = bus.instr_valid ? bus.pc + 32'd4 : bus.pc;
    endtask

    task automatic do_reset();
        rst_hold = 1'b1;
        repeat (2) step();
        rst_hold = 1'b0;
    endtask

    initial begin
        int s;
        int t;
        bus.pc = 32'h0;
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata = 32'h0;

        rst_hold = 1'b1;
        repeat (3) step();
        check("rst_req", 32'(bus.mem_req), 32'd0);
        check("rst_addr", bus.mem_addr, 32'h0);
        check("rst_instr", bus.instr, 32'h0);
        check("rst_valid", 32'(bus.instr_valid), 32'd0);

        rst_hold = 1'b0;
        gnt_pct = 100; rsp_pct = 100; jump_pct = 0;
        repeat (16) step();
        check("b_req0", 32'(log_req[0]), 32'd0);
        check("b_req1", 32'(log_req[1]), 32'd1);
        check("b_addr1", log_addr[1], 32'h0);
        check("b_addr2", log_addr[2], 32'h4);
        check("b_addr3", log_addr[3], 32'h8);
        check("b_valid2", 32'(log_valid[2]), 32'd0);
        check("b_valid3", 32'(log_valid[3]), 32'd1);
        check("b_instr3", log_instr[3], 32'hA5A5A5A5);
        check("b_instr4", log_instr[4], 32'hA5A5A5A1);
        s = 0;
        for (int i = 3; i < 16; i++) s += int'(log_valid[i]);
        check("b_stream", s, 13);

        force_pc = 32'hFFFF_FFF8;
        force_jump = 1'b1;
        step();
        t = cyc;
        repeat (8) step();
        check("d_req", 32'(log_req[t+1]), 32'd1);
        check("d_addr1", log_addr[t+1], 32'hFFFF_FFF8);
        check("d_addr2", log_addr[t+2], 32'hFFFF_FFFC);
        check("d_addr3", log_addr[t+3], 32'h0);
        check("d_drop1", 32'(log_valid[t+1]), 32'd0);
        check("d_drop2", 32'(log_valid[t+2]), 32'd0);
        check("d_instr3", log_instr[t+3], 32'h5A5A5A5D);
        check("d_instr4", log_instr[t+4], 32'h5A5A5A59);
        check("d_instr5", log_instr[t+5], 32'hA5A5A5A5);

        do_reset();
        n_grants = 0;
        gnt_pct = 100; rsp_pct = 0;
        repeat (20) step();
        check("c_grants", n_grants, DEPTH);
        s = 0;
        for (int i = 8; i < 20; i++) s += int'(log_req[i]);
        check("c_req_low", s, 0);
        rsp_pct = 100;
        repeat (6) step();
        check("c_valid20", 32'(log_valid[20]), 32'd0);
        check("c_valid21", 32'(log_valid[21]), 32'd1);
        check("c_instr21", log_instr[21], 32'hA5A5A5A5);
        check("c_req21", 32'(log_req[21]), 32'd0);
        check("c_req22", 32'(log_req[22]), 32'd1);

        do_reset();
        gnt_pct = 100; rsp_pct = 0;
        repeat (3) step();
        gnt_pct = 0;
        force_pc = 32'h100;
        force_jump = 1'b1;
        step();
        gnt_pct = 100; rsp_pct = 100;
        repeat (8) step();
        check("r_pend3", log_addr[3], 32'h8);
        check("r_pend4", log_addr[4], 32'h8);
        check("r_addr5", log_addr[5], 32'h100);
        s = 0;
        for (int i = 3; i < 8; i++) s += int'(log_valid[i]);
        check("r_no_early", s, 0);
        check("r_valid8", 32'(log_valid[8]), 32'd1);
        check("r_instr8", log_instr[8], 32'hA5A5A4A5);

        do_reset();
        gnt_pct = 70; rsp_pct = 60; jump_pct = 4;
        idle = 0; n_valid = 0; live_chk = 1'b1;
        repeat (3000) step();
        live_chk = 1'b0;
        check("e_throughput", 32'(n_valid > 500), 32'd1);
        reset = 1'b1;
        #1;
        check("e_rst_req", 32'(bus.mem_req), 32'd0);
        check("e_rst_addr", bus.mem_addr, 32'h0);
        check("e_rst_instr", bus.instr, 32'h0);
        check("e_rst_valid", 32'(bus.instr_valid), 32'd0);
        do_reset();
        gnt_pct = 100; rsp_pct = 100; jump_pct = 0;
        repeat (6) step();
        check("e_req1", 32'(log_req[1]), 32'd1);
        check("e_addr1", log_addr[1], 32'h0);
        check("e_valid3", 32'(log_valid[3]), 32'd1);

        gnt_pct = 90; rsp_pct = 90; jump_pct = 10;
        repeat (1500) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
